l2_request_arbiter: RTL

L2_REQUEST_ARBITER -- requirements
Module: l2_request_arbiter

---
 rtl/l2_request_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/l2_request_arbiter.sv
// Funnels NUM_CORES request streams into one registered L2 request slot.
// One grant per cycle (round-robin or fixed priority), one cycle of latency.
module l2_request_arbiter #(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned CORE_ID_WIDTH  = 4,
    parameter int unsigned PACKET_WIDTH   = 128,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_CORES-1:0]              core_req_valid,
    input  logic [NUM_CORES*PACKET_WIDTH-1:0] core_req_packet,
    output logic [NUM_CORES-1:0]              core_req_ready,
    output logic                              l2req_valid,
    output logic [PACKET_WIDTH-1:0]           l2req_packet,
    output logic [CORE_ID_WIDTH-1:0]          l2req_core,
    input  logic                              l2req_ready
);
    localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic                     r_valid;
    logic [PACKET_WIDTH-1:0]  r_packet;
    logic [CORE_ID_WIDTH-1:0] r_core;
    logic                     w_free;
    logic                     w_any;
    logic                     w_grant;
    logic [IDX_W-1:0]         w_idx;
    logic [PACKET_WIDTH-1:0]  w_pkt;

    // Gating with reset_n keeps core_req_ready low for the whole reset interval.
    assign w_free  = reset_n && (!r_valid || l2req_ready);
    assign w_any   = |core_req_valid;
    assign w_grant = w_free && w_any;

    generate
        if (NUM_CORES == 1) begin : g_single
            assign w_idx             = '0;
            assign w_pkt             = core_req_packet;
            assign core_req_ready[0] = w_grant;
        end else begin : g_multi
            logic [IDX_W-1:0] r_ptr;
            logic [IDX_W-1:0] w_sel;
            logic [IDX_W-1:0] w_cand;
            logic             w_found;
            int unsigned      w_sum;

            // Search starts just past the last winner and wraps; fixed mode starts at core 0.
            always_comb begin
                w_found = 1'b0;
                w_sel   = '0;
                w_cand  = '0;
                w_sum   = 0;
                for (int unsigned i = 0; i < NUM_CORES; i++) begin
                    w_sum = (FIXED_PRIORITY ? 32'd0 : (32'(r_ptr) + 32'd1)) + i;
                    if (w_sum >= NUM_CORES) begin
                        w_sum = w_sum - NUM_CORES;
                    end
                    w_cand = IDX_W'(w_sum);
                    if (!w_found && core_req_valid[w_cand]) begin
                        w_found = 1'b1;
                        w_sel   = w_cand;
                    end
                end
            end

            assign w_idx = w_sel;
            assign w_pkt = core_req_packet[w_idx*PACKET_WIDTH +: PACKET_WIDTH];

            always_comb begin
                core_req_ready = '0;
                if (w_grant) begin
                    core_req_ready[w_idx] = 1'b1;
                end
            end

            // Reset value NUM_CORES-1 makes core 0 the first candidate.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_ptr <= IDX_W'(NUM_CORES - 1);
                end else if (w_grant) begin
                    r_ptr <= w_idx;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= 1'b0;
            r_packet <= '0;
            r_core   <= '0;
        end else if (w_free) begin
            r_valid <= w_any;
            if (w_any) begin
                r_packet <= w_pkt;
                r_core   <= CORE_ID_WIDTH'(w_idx);
            end
        end
    end

    assign l2req_valid  = r_valid;
    assign l2req_packet = r_packet;
    assign l2req_core   = r_core;

endmodule
